// File: rtl/tproj_page_buffer.sv
// rtl/tproj_page_buffer.sv - double-buffered projection page store with per-BX count/overflow/tag
//
// Ports:
//   proc_clk  in   processing clock, rising edge
//   reset     in   asynchronous active-low reset
//   valid     in   projin carries a projection this cycle
//   projin    in   55-bit projection word, [54:51] layer/disk tag (0 = empty)
//   start     in   one-cycle BX boundary strobe
//   read_add  in   read address into the read page
//   data_out  out  registered read data from the read page
//   nent_out  out  entry count of the read page (0..2^DEPTH_LOG2)
//   overflow  out  read page dropped at least one projection
//   bx_out    out  BX tag of the read page
module tproj_page_buffer #(
  parameter int DEPTH_LOG2 = 6,
  parameter int BX_BITS    = 3
) (
  input  logic                  proc_clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [54:0]           projin,
  input  logic                  start,
  input  logic [DEPTH_LOG2-1:0] read_add,
  output logic [54:0]           data_out,
  output logic [DEPTH_LOG2:0]   nent_out,
  output logic                  overflow,
  output logic [BX_BITS-1:0]    bx_out
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [54:0] mem [0:2*DEPTH-1];

  logic                  wpage_q, wpage_d;
  logic [DEPTH_LOG2:0]   wptr_q, wptr_d;
  logic                  ovf_w_q, ovf_w_d;
  logic [BX_BITS-1:0]    bx_w_q, bx_w_d;
  logic [DEPTH_LOG2:0]   nent_q, nent_d;
  logic                  ovf_r_q, ovf_r_d;
  logic [BX_BITS-1:0]    bx_r_q, bx_r_d;
  logic [54:0]           data_q;

  logic                  word_ok;
  logic                  wr_en;
  logic                  wr_page;
  logic [DEPTH_LOG2-1:0] wr_off;
  logic [DEPTH_LOG2:0]   wr_addr;
  logic [DEPTH_LOG2:0]   rd_addr;

  assign word_ok = valid && (projin[54:51] != 4'd0);
  // A word arriving with start belongs to the new BX, whose page is empty,
  // so it is always accepted at offset 0 of the page about to be written.
  assign wr_en   = word_ok && (start || (wptr_q != FULL));
  assign wr_page = start ? ~wpage_q : wpage_q;
  assign wr_off  = start ? '0 : wptr_q[DEPTH_LOG2-1:0];
  assign wr_addr = {wr_page, wr_off};
  // Read uses the page select from before the edge, so a read issued with
  // start still sees the outgoing read page.
  assign rd_addr = {~wpage_q, read_add};

  always_comb begin
    wpage_d = wpage_q;
    wptr_d  = wptr_q;
    ovf_w_d = ovf_w_q;
    bx_w_d  = bx_w_q;
    nent_d  = nent_q;
    ovf_r_d = ovf_r_q;
    bx_r_d  = bx_r_q;
    if (start) begin
      nent_d  = wptr_q;
      ovf_r_d = ovf_w_q;
      bx_r_d  = bx_w_q;
      wpage_d = ~wpage_q;
      bx_w_d  = bx_w_q + 1'b1;
      wptr_d  = {{DEPTH_LOG2{1'b0}}, word_ok};
      ovf_w_d = 1'b0;
    end else if (wr_en) begin
      wptr_d = wptr_q + 1'b1;
    end else if (word_ok) begin
      // Page full: drop the word, flag sticks until the next boundary.
      ovf_w_d = 1'b1;
    end
  end

  // Storage has no reset; stale contents are bounded by nent_out.
  always_ff @(posedge proc_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= projin;
    end
  end

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      wpage_q <= 1'b0;
      wptr_q  <= '0;
      ovf_w_q <= 1'b0;
      bx_w_q  <= '0;
      nent_q  <= '0;
      ovf_r_q <= 1'b0;
      bx_r_q  <= '0;
      data_q  <= '0;
    end else begin
      wpage_q <= wpage_d;
      wptr_q  <= wptr_d;
      ovf_w_q <= ovf_w_d;
      bx_w_q  <= bx_w_d;
      nent_q  <= nent_d;
      ovf_r_q <= ovf_r_d;
      bx_r_q  <= bx_r_d;
      data_q  <= mem[rd_addr];
    end
  end

  assign data_out = data_q;
  assign nent_out = nent_q;
  assign overflow = ovf_r_q;
  assign bx_out   = bx_r_q;

endmodule

// File: tb/tb_tproj_page_buffer.sv
// tb/tb_tproj_page_buffer.sv - directed self-checking bench for tproj_page_buffer
module tb_tproj_page_buffer;

  logic        proc_clk;
  logic        reset;
  logic        valid;
  logic [54:0] projin;
  logic        start;
  logic [5:0]  read_add;
  logic [54:0] data_out;
  logic [6:0]  nent_out;
  logic        overflow;
  logic [2:0]  bx_out;

  int checks = 0;
  int errors = 0;
  logic [2:0] bxm;
  logic [54:0] pw [0:3];
  logic [54:0] qw [0:3];

  tproj_page_buffer #(.DEPTH_LOG2(6), .BX_BITS(3)) dut (
    .proc_clk (proc_clk),
    .reset    (reset),
    .valid    (valid),
    .projin   (projin),
    .start    (start),
    .read_add (read_add),
    .data_out (data_out),
    .nent_out (nent_out),
    .overflow (overflow),
    .bx_out   (bx_out)
  );

  initial proc_clk = 1'b0;
  always #5 proc_clk = ~proc_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [54:0] mkw(input logic [3:0] tag, input int n);
    logic [50:0] d;
    d = 51'h2000000000000 | 51'(n);
    return {tag, d};
  endfunction

  // Drive one cycle of inputs, clock it, settle 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [54:0] p, input logic s, input logic [5:0] ra);
    valid = v; projin = p; start = s; read_add = ra;
    @(posedge proc_clk);
    #1;
    valid = 1'b0; projin = '0; start = 1'b0;
  endtask

  task automatic do_start(input logic v, input logic [54:0] p, input int exp_n,
                          input logic exp_o, input string tag);
    cyc(v, p, 1'b1, 6'd0);
    check({tag, "_nent"}, 64'(nent_out), 64'(exp_n));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_o));
    check({tag, "_bx"}, 64'(bx_out), 64'(bxm));
    bxm = bxm + 3'd1;
  endtask

  task automatic rd(input logic [5:0] a, input logic [54:0] exp, input string tag);
    cyc(1'b0, '0, 1'b0, a);
    check(tag, 64'(data_out), 64'(exp));
  endtask

  initial begin
    reset = 1'b0; valid = 1'b0; projin = '0; start = 1'b0; read_add = '0;
    bxm = '0;
    #3;
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_nent", 64'(nent_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_bx", 64'(bx_out), 64'd0);
    @(posedge proc_clk); #1;
    reset = 1'b1;

    // Basic BX
    do_start(1'b0, '0, 0, 1'b0, "b0");
    for (int i = 1; i <= 5; i++) cyc(1'b1, mkw(4'(i), i), 1'b0, 6'd0);
    do_start(1'b0, '0, 5, 1'b0, "b1");
    for (int i = 0; i < 5; i++) rd(6'(i), mkw(4'(i + 1), i + 1), "basic_rd");

    // Empty-tag filter
    for (int i = 0; i < 3; i++) cyc(1'b1, {4'd0, 51'(i + 77)}, 1'b0, 6'd0);
    cyc(1'b1, mkw(4'h3, 200), 1'b0, 6'd0);
    cyc(1'b1, mkw(4'h3, 201), 1'b0, 6'd0);
    do_start(1'b0, '0, 2, 1'b0, "filt");
    rd(6'd0, mkw(4'h3, 200), "filt_rd0");
    rd(6'd1, mkw(4'h3, 201), "filt_rd1");

    // Overflow
    for (int i = 0; i < 70; i++) cyc(1'b1, mkw(4'h7, i), 1'b0, 6'd0);
    do_start(1'b0, '0, 64, 1'b1, "ovf");
    rd(6'd0, mkw(4'h7, 0), "ovf_rd0");
    rd(6'd63, mkw(4'h7, 63), "ovf_rd63");
    cyc(1'b1, mkw(4'h9, 0), 1'b0, 6'd0);
    do_start(1'b0, '0, 1, 1'b0, "ovf_next");
    rd(6'd0, mkw(4'h9, 0), "ovf_next_rd0");

    // Word coinciding with start
    cyc(1'b1, mkw(4'h2, 300), 1'b0, 6'd0);
    cyc(1'b1, mkw(4'h2, 301), 1'b0, 6'd0);
    do_start(1'b1, mkw(4'hA, 0), 2, 1'b0, "sim_prev");
    cyc(1'b1, mkw(4'hB, 1), 1'b0, 6'd0);
    cyc(1'b1, mkw(4'hC, 2), 1'b0, 6'd0);
    do_start(1'b0, '0, 3, 1'b0, "sim");
    rd(6'd0, mkw(4'hA, 0), "sim_rd0");
    rd(6'd1, mkw(4'hB, 1), "sim_rd1");
    rd(6'd2, mkw(4'hC, 2), "sim_rd2");

    // Back-to-back boundaries
    do_start(1'b0, '0, 0, 1'b0, "b2b_a");
    do_start(1'b0, '0, 0, 1'b0, "b2b_b");
    do_start(1'b1, mkw(4'h6, 5), 0, 1'b0, "b2b_c");
    do_start(1'b0, '0, 1, 1'b0, "b2b_d");
    rd(6'd0, mkw(4'h6, 5), "b2b_rd0");

    // Ping-pong integrity
    for (int i = 0; i < 4; i++) begin
      pw[i] = mkw(4'h5, 100 + i);
      qw[i] = mkw(4'hE, 400 + i);
      cyc(1'b1, pw[i], 1'b0, 6'd0);
    end
    do_start(1'b0, '0, 4, 1'b0, "pp_a");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, qw[i], 1'b0, 6'(i));
      check("pp_rd_p", 64'(data_out), 64'(pw[i]));
    end
    do_start(1'b0, '0, 4, 1'b0, "pp_b");
    for (int i = 0; i < 4; i++) rd(6'(i), qw[i], "pp_rd_q");

    // Asynchronous reset mid-BX
    for (int i = 0; i < 10; i++) cyc(1'b1, mkw(4'h8, 500 + i), 1'b0, 6'd0);
    check("pre_rst_data", 64'(data_out), 64'(qw[0]));
    #2;
    reset = 1'b0;
    #1;
    check("arst_data", 64'(data_out), 64'd0);
    check("arst_nent", 64'(nent_out), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    check("arst_bx", 64'(bx_out), 64'd0);
    @(posedge proc_clk); #1;
    reset = 1'b1;
    bxm = '0;
    do_start(1'b0, '0, 0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tproj_page_buffer.md
# tproj_page_buffer

Double-buffered projection store that sits directly downstream of the projection receive FIFO stage. It captures the 55-bit projection words that arrive with `valid` during one bunch crossing (BX) into one RAM page. It then presents that page, read-only, to the match engine during the next BX while the other page fills. Each page holds up to 64 entries, and an entry count and overflow flag are reported per BX.

## Interface
- `DEPTH_LOG2`, default 6: address width per page; 64 entries per page.
- `BX_BITS`, default 3: width of the BX tag counter.
- `proc_clk` in 1: the single processing clock; all logic is on its rising edge.
- `reset` in 1: reset, asynchronous and active-low. Asserting it (0) immediately clears all state; release is synchronous to `proc_clk`.
- `valid` in 1: `projin` holds a projection this cycle.
- `projin` in 55: projection word. `[54:51]` is the layer/disk tag; 0 means empty.
- `start` in 1: one-cycle BX boundary strobe.
- `read_add` in DEPTH_LOG2: read address into the read page.
- `data_out` out 55: registered read data.
- `nent_out` out DEPTH_LOG2+1: number of entries in the read page, 0..64.
- `overflow` out 1: the read page lost at least one projection.
- `bx_out` out BX_BITS: BX tag of the read page.

## Operation
- State:
  - `wpage` (1 bit): page being written. The read page is `~wpage`.
  - `wptr` (DEPTH_LOG2+1 bits): write pointer, 0..64.
  - `ovf_w`: overflow flag for the write page.
  - `bx_w`: BX tag of the write page.
  - RAM of 2×64×55 bits, one write port and one read port.
- Write acceptance: a write occurs when `valid`=1, `projin[54:51]`≠0 and `wptr`<64. Words with tag 0 are silently dropped and do not count.
- On an accepted write, `projin` goes to address {`wpage`, `wptr[5:0]`} and `wptr` increments.
- Full page: with `wptr`=64, an incoming `valid` word with a nonzero tag is discarded and `ovf_w` is set. Overflow is sticky until the next `start`. `wptr` never wraps.
- On `start`=1:
  - `nent_out`←`wptr`, `overflow`←`ovf_w`, `bx_out`←`bx_w`.
  - `wpage` toggles; `bx_w` increments modulo 2^BX_BITS.
  - `wptr`←0 and `ovf_w`←0. The new write page is treated as empty; the RAM is not cleared.
- `start` coinciding with a qualifying `valid`: the word belongs to the new BX. It is written to address {~old `wpage`, 0}, and `wptr` becomes 1 after the edge. The latched `nent_out` excludes it.
- Back-to-back `start` on consecutive cycles: each is an independent boundary. The second latches `nent_out`=0, or 1 if a word arrived with the first `start`.
- Read side: `data_out` ← RAM[{~`wpage`, `read_add`}].
  - Addresses ≥ `nent_out` return stale data. The consumer must bound its reads by `nent_out`.
- Reset mid-BX: all in-flight contents are abandoned. After release the block behaves as after power-up, with page 0 being written.

## Timing
- Reset values:
  - outputs: `data_out`=0, `nent_out`=0, `overflow`=0, `bx_out`=0.
  - internal: `wpage`=0, `wptr`=0, `ovf_w`=0, `bx_w`=0.
- Write latency: a word accepted at edge N is readable from the read page after the next `start` edge.
- Read latency: 1 cycle. `read_add` sampled at edge N gives `data_out` valid after edge N; the read uses the `wpage` value from before that edge.
- `nent_out`, `overflow` and `bx_out` update on the `start` edge and are stable for the entire following BX.
- Read in the same cycle as `start`: `data_out` reflects the old read page, which is the page now being rewritten. On the cycle after `start`, reads see the newly swapped page.
- Throughput: one write and one read per cycle, with no stalls and no backpressure to upstream.

## Test plan
- Basic BX: reset, `start`, then 5 `valid` words with tags 1..5, then `start`. Require `nent_out`=5, `overflow`=0 and `bx_out`=1. Reading addresses 0..4 returns the 5 words in order, each one cycle after its address.
- Empty filter: 3 `valid` words with `projin[54:51]`=0 and 2 words with tag 0x3, then `start`. Require `nent_out`=2, containing only the tagged words.
- Overflow: 70 qualifying words in one BX, then `start`. Require `nent_out`=64 and `overflow`=1; address 63 holds the 64th word. The next BX with 1 word gives `nent_out`=1 and `overflow`=0.
- Simultaneous event: a word 0xA on the same cycle as `start`, 2 more words, then `start`. Require `nent_out`=3 with address 0 = 0xA; the previous BX count excludes 0xA.
- Ping-pong integrity: fill page A with pattern P, `start`, fill page B with Q while reading A. Reads always return P; after the next `start`, reads return Q and `bx_out` increments by 1.
- Async reset: assert `reset`=0 mid-BX after 10 writes, with no clock edge. Outputs go to 0 immediately. After release, `start` gives `nent_out`=0 and `bx_out`=0.
